// File: rtl/branch_resolve_unit.sv
// rtl/branch_resolve_unit.sv - MIPS conditional branch resolver with 2-entry result buffer
//
// Purpose:
//   Resolves a conditional branch from EX-stage ALU flags (S/Z/N/V).
//   Computes the direction, target and mispredict redirect for the branch,
//   then queues up to two results toward the PC unit behind a valid/ready
//   handshake. A mispredicted head that is popped discards every younger
//   entry, including one being pushed on the same edge.
//   Optional macro BRU_STATS_EN builds saturating branch/mispredict counters;
//   without it both stat ports are tied to zero.
//
// Ports:
//   clk, reset        rising-edge clock, synchronous active-high reset
//   flush             synchronous pipeline flush (empties the buffer)
//   in_valid/in_ready EX-side handshake; in_ready is registered (count < 2)
//   br_op             condition select
//   alu_s/z/n/v       compare result flags (only alu_s[0] used)
//   pc_plus4, offset  branch PC + 4 and sign-extended word offset
//   pred_taken        fetch-stage prediction
//   out_valid/out_ready  PC-unit handshake
//   taken, target, mispredict, redirect_pc  head-of-buffer result
//   stat_branches, stat_mispred             event counters
module branch_resolve_unit #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned W     = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [2:0]   br_op,
  input  logic [31:0]  alu_s,
  input  logic         alu_z,
  input  logic         alu_n,
  input  logic         alu_v,
  input  logic [W-1:0] pc_plus4,
  input  logic [W-1:0] offset,
  input  logic         pred_taken,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         taken,
  output logic [W-1:0] target,
  output logic         mispredict,
  output logic [W-1:0] redirect_pc,
  output logic [31:0]  stat_branches,
  output logic [31:0]  stat_mispred
);

  // Entry layout: {taken, mispredict, target, redirect_pc}
  localparam int unsigned EW = 2 * W + 2;

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_FULL  = 2'd2
  } state_t;

  state_t         r_state;
  state_t         w_next_state;
  logic           r_in_ready;
  logic [EW-1:0]  r_slot0;
  logic [EW-1:0]  r_slot1;

  logic           w_lt;
  logic           w_taken;
  logic [W-1:0]   w_target;
  logic [EW-1:0]  w_new;
  logic [EW-1:0]  w_head;
  logic           w_push;
  logic           w_pop;
  logic           w_kill;
  logic           w_unused_alu_s;

  assign w_unused_alu_s = &{1'b0, alu_s[31:1]};

  assign w_lt = alu_n ^ alu_v;

  always_comb begin
    w_taken = 1'b0;
    case (br_op)
      3'b000:  w_taken = alu_z;
      3'b001:  w_taken = ~alu_z;
      3'b010:  w_taken = w_lt;
      3'b011:  w_taken = ~w_lt;
      3'b100:  w_taken = w_lt | alu_z;
      3'b101:  w_taken = ~w_lt & ~alu_z;
      3'b110:  w_taken = alu_s[0];
      default: w_taken = 1'b0;
    endcase
  end

  assign w_target = pc_plus4 + (offset << 2);
  assign w_new    = {w_taken, w_taken ^ pred_taken, w_target,
                     w_taken ? w_target : pc_plus4};

  // Outputs read zero whenever the buffer is empty, so stale slot data
  // after a pop, kill or flush never leaks to the PC unit.
  assign w_head = (r_state != S_EMPTY) ? r_slot0 : '0;
  assign {taken, mispredict, target, redirect_pc} = w_head;

  assign out_valid = (r_state != S_EMPTY);
  assign in_ready  = r_in_ready;

  assign w_push = in_valid & r_in_ready;
  assign w_pop  = out_valid & out_ready;
  assign w_kill = w_pop & mispredict;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_EMPTY;
      r_in_ready <= 1'b1;
    end else begin
      r_state    <= w_next_state;
      r_in_ready <= (32'(w_next_state) < DEPTH);
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_EMPTY: if (w_push) w_next_state = S_ONE;
      S_ONE: begin
        if (w_kill)                w_next_state = S_EMPTY;
        else if (w_push && !w_pop) w_next_state = S_FULL;
        else if (w_pop && !w_push) w_next_state = S_EMPTY;
      end
      // in_ready is low in FULL, so no push can land here.
      S_FULL:  if (w_pop) w_next_state = w_kill ? S_EMPTY : S_ONE;
      default: w_next_state = S_EMPTY;
    endcase
    if (flush) w_next_state = S_EMPTY;
  end

  // Slot 0 is always the head; slot 1 shifts down on pop.
  always_ff @(posedge clk) begin
    if (!reset && !flush && !w_kill) begin
      if (w_pop && w_push) begin
        r_slot0 <= w_new;
      end else if (w_pop) begin
        r_slot0 <= r_slot1;
      end else if (w_push) begin
        if (r_state == S_EMPTY) r_slot0 <= w_new;
        else                    r_slot1 <= w_new;
      end
    end
  end

`ifdef BRU_STATS_EN
  logic [31:0] r_stat_br;
  logic [31:0] r_stat_mis;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_stat_br  <= '0;
      r_stat_mis <= '0;
    end else if (w_pop && !flush) begin
      if (r_stat_br != '1)                r_stat_br  <= r_stat_br + 32'd1;
      if (mispredict && r_stat_mis != '1) r_stat_mis <= r_stat_mis + 32'd1;
    end
  end

  assign stat_branches = r_stat_br;
  assign stat_mispred  = r_stat_mis;
`else
  assign stat_branches = '0;
  assign stat_mispred  = '0;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// tb/tb_branch_resolve_unit.sv - directed vector bench for branch_resolve_unit
module tb_branch_resolve_unit;

  logic        clk;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  br_op;
  logic [31:0] alu_s;
  logic        alu_z;
  logic        alu_n;
  logic        alu_v;
  logic [31:0] pc_plus4;
  logic [31:0] offset;
  logic        pred_taken;
  logic        out_valid;
  logic        out_ready;
  logic        taken;
  logic [31:0] target;
  logic        mispredict;
  logic [31:0] redirect_pc;
  logic [31:0] stat_branches;
  logic [31:0] stat_mispred;

  branch_resolve_unit #(.DEPTH(2), .W(32)) dut (
    .clk          (clk),
    .reset        (reset),
    .flush        (flush),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .br_op        (br_op),
    .alu_s        (alu_s),
    .alu_z        (alu_z),
    .alu_n        (alu_n),
    .alu_v        (alu_v),
    .pc_plus4     (pc_plus4),
    .offset       (offset),
    .pred_taken   (pred_taken),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .taken        (taken),
    .target       (target),
    .mispredict   (mispredict),
    .redirect_pc  (redirect_pc),
    .stat_branches(stat_branches),
    .stat_mispred (stat_mispred)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] s;
    logic        z;
    logic        n;
    logic        v;
    logic [31:0] pc;
    logic [31:0] off;
    logic        pred;
    logic        e_taken;
    logic [31:0] e_target;
    logic        e_mis;
    logic [31:0] e_redir;
  } vec_t;

  vec_t vt [11];
  int   n_cmp  = 0;
  int   n_fail = 0;
  int   exp_br = 0;
  int   exp_mis = 0;

  function automatic vec_t mk(input logic [2:0] op, input logic [31:0] s,
                              input logic z, input logic n, input logic v,
                              input logic [31:0] pc, input logic [31:0] off,
                              input logic pred, input logic et,
                              input logic [31:0] etg, input logic em,
                              input logic [31:0] er);
    vec_t r;
    r.op = op; r.s = s; r.z = z; r.n = n; r.v = v;
    r.pc = pc; r.off = off; r.pred = pred;
    r.e_taken = et; r.e_target = etg; r.e_mis = em; r.e_redir = er;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic apply(input vec_t v);
    br_op = v.op; alu_s = v.s; alu_z = v.z; alu_n = v.n; alu_v = v.v;
    pc_plus4 = v.pc; offset = v.off; pred_taken = v.pred;
  endtask

  task automatic check_head(input string name, input vec_t v);
    chk({name, ".out_valid"},   32'(out_valid),  32'd1);
    chk({name, ".taken"},       32'(taken),      32'(v.e_taken));
    chk({name, ".target"},      target,          v.e_target);
    chk({name, ".mispredict"},  32'(mispredict), 32'(v.e_mis));
    chk({name, ".redirect_pc"}, redirect_pc,     v.e_redir);
  endtask

  task automatic note_pop(input logic mis);
    exp_br++;
    if (mis) exp_mis++;
  endtask

  task automatic check_stats(input string name);
`ifdef BRU_STATS_EN
    chk({name, ".stat_branches"}, stat_branches, 32'(exp_br));
    chk({name, ".stat_mispred"},  stat_mispred,  32'(exp_mis));
`else
    chk({name, ".stat_branches"}, stat_branches, 32'd0);
    chk({name, ".stat_mispred"},  stat_mispred,  32'd0);
`endif
  endtask

  task automatic check_empty(input string name);
    chk({name, ".out_valid"},   32'(out_valid),  32'd0);
    chk({name, ".in_ready"},    32'(in_ready),   32'd1);
    chk({name, ".taken"},       32'(taken),      32'd0);
    chk({name, ".target"},      target,          32'd0);
    chk({name, ".mispredict"},  32'(mispredict), 32'd0);
    chk({name, ".redirect_pc"}, redirect_pc,     32'd0);
    check_stats(name);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //            op      s             z     n     v     pc            off           pred  tk    target        mis   redirect
    vt[0]  = mk(3'b000, 32'h0,        1'b1, 1'b0, 1'b0, 32'h00400004, 32'h00000003, 1'b1, 1'b1, 32'h00400010, 1'b0, 32'h00400010);
    vt[1]  = mk(3'b010, 32'h0,        1'b0, 1'b1, 1'b1, 32'h00000100, 32'h00000000, 1'b1, 1'b0, 32'h00000100, 1'b1, 32'h00000100);
    vt[2]  = mk(3'b001, 32'h0,        1'b0, 1'b0, 1'b0, 32'hFFFFFFFC, 32'h00000001, 1'b1, 1'b1, 32'h00000000, 1'b0, 32'h00000000);
    vt[3]  = mk(3'b011, 32'h0,        1'b0, 1'b1, 1'b0, 32'h00001000, 32'hFFFFFFFF, 1'b0, 1'b0, 32'h00000FFC, 1'b0, 32'h00001000);
    vt[4]  = mk(3'b100, 32'h0,        1'b1, 1'b0, 1'b0, 32'h00002000, 32'h00000010, 1'b0, 1'b1, 32'h00002040, 1'b1, 32'h00002040);
    vt[5]  = mk(3'b101, 32'h0,        1'b0, 1'b0, 1'b1, 32'h00003000, 32'h00000002, 1'b1, 1'b0, 32'h00003008, 1'b1, 32'h00003000);
    vt[6]  = mk(3'b101, 32'h0,        1'b0, 1'b0, 1'b0, 32'h00003000, 32'h00000002, 1'b1, 1'b1, 32'h00003008, 1'b0, 32'h00003008);
    vt[7]  = mk(3'b110, 32'h00000003, 1'b0, 1'b0, 1'b0, 32'h00000040, 32'h00000004, 1'b0, 1'b1, 32'h00000050, 1'b1, 32'h00000050);
    vt[8]  = mk(3'b110, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0, 32'h00000040, 32'h00000004, 1'b0, 1'b0, 32'h00000050, 1'b0, 32'h00000040);
    vt[9]  = mk(3'b111, 32'h00000001, 1'b1, 1'b1, 1'b0, 32'h00000080, 32'h00000001, 1'b1, 1'b0, 32'h00000084, 1'b1, 32'h00000080);
    vt[10] = mk(3'b010, 32'h0,        1'b0, 1'b1, 1'b0, 32'h00000100, 32'h00000008, 1'b1, 1'b1, 32'h00000120, 1'b0, 32'h00000120);

    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    apply(vt[0]);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_empty("reset");

    // Single-branch vectors: push, check next cycle, pop.
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      apply(vt[i]);
      in_valid = 1'b1; out_ready = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      check_head($sformatf("vec%0d", i), vt[i]);
      chk($sformatf("vec%0d.in_ready", i), 32'(in_ready), 32'd1);
      note_pop(vt[i].e_mis);
    end
    @(negedge clk);
    chk("table_drain.out_valid", 32'(out_valid), 32'd0);
    check_stats("table_drain");

    // Backpressure: three back-to-back pushes with out_ready low.
    out_ready = 1'b0;
    apply(vt[0]); in_valid = 1'b1;
    @(negedge clk);
    chk("bp1.in_ready", 32'(in_ready), 32'd1);
    check_head("bp1", vt[0]);
    apply(vt[6]);
    @(negedge clk);
    chk("bp2.in_ready", 32'(in_ready), 32'd0);
    check_head("bp2", vt[0]);
    apply(vt[10]);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk($sformatf("bp_hold%0d.in_ready", k), 32'(in_ready), 32'd0);
      check_head($sformatf("bp_hold%0d", k), vt[0]);
    end
    out_ready = 1'b1;
    @(negedge clk);
    note_pop(1'b0);
    chk("bp_pop1.in_ready", 32'(in_ready), 32'd1);
    check_head("bp_pop1", vt[6]);
    @(negedge clk);
    note_pop(1'b0);
    in_valid = 1'b0;
    chk("bp_pop2.in_ready", 32'(in_ready), 32'd1);
    check_head("bp_pop2", vt[10]);
    @(negedge clk);
    note_pop(1'b0);
    chk("bp_drain.out_valid", 32'(out_valid), 32'd0);
    check_stats("bp_drain");

    // Mispredict kill with both entries full.
    out_ready = 1'b0;
    apply(vt[1]); in_valid = 1'b1;
    @(negedge clk);
    apply(vt[0]);
    @(negedge clk);
    chk("kill2.in_ready", 32'(in_ready), 32'd0);
    check_head("kill2", vt[1]);
    apply(vt[6]); out_ready = 1'b1;
    @(negedge clk);
    note_pop(1'b1);
    in_valid = 1'b0; out_ready = 1'b0;
    check_empty("kill2_after");
    @(negedge clk);
    chk("kill2_settle.out_valid", 32'(out_valid), 32'd0);

    // Mispredict kill from one entry while a younger push lands.
    apply(vt[1]); in_valid = 1'b1;
    @(negedge clk);
    check_head("kill1", vt[1]);
    apply(vt[0]); out_ready = 1'b1;
    @(negedge clk);
    note_pop(1'b1);
    in_valid = 1'b0; out_ready = 1'b0;
    check_empty("kill1_after");
    @(negedge clk);
    chk("kill1_settle.out_valid", 32'(out_valid), 32'd0);

    // Flush at count 2 with push and pop requested.
    apply(vt[0]); in_valid = 1'b1;
    @(negedge clk);
    apply(vt[6]);
    @(negedge clk);
    apply(vt[10]); out_ready = 1'b1; flush = 1'b1;
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    check_empty("flush2");

    // Flush at count 1 with push and pop requested.
    apply(vt[0]); in_valid = 1'b1;
    @(negedge clk);
    apply(vt[6]); out_ready = 1'b1; flush = 1'b1;
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    check_empty("flush1");
    @(negedge clk);
    chk("flush1_settle.out_valid", 32'(out_valid), 32'd0);

    // Recovery after flush.
    apply(vt[4]); in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    check_head("recover", vt[4]);
    note_pop(1'b1);
    @(negedge clk);
    out_ready = 1'b0;
    chk("recover.out_valid", 32'(out_valid), 32'd0);
    check_stats("recover");

    // Reset mid-stream.
    apply(vt[0]); in_valid = 1'b1;
    @(negedge clk);
    apply(vt[6]);
    @(negedge clk);
    reset = 1'b1; in_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    exp_br = 0; exp_mis = 0;
    check_empty("midreset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
- Consumer end of the ALU flag interface.
- Takes the S/Z/V/N result of an EX-stage compare (SUB/EQ/NEQ-class ALU ops) and resolves a MIPS conditional branch: taken/not-taken, target, and misprediction redirect toward the PC unit.
- Buffers up to two resolved branches behind a valid/ready handshake.
- Discards the younger wrong-path entry automatically when a mispredict is delivered.

Parameters:
- DEPTH, 2, result buffer entries; fixed at 2, other values are illegal.
- W, 32, datapath width of PC and offset.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- flush  input  1  synchronous pipeline flush; clears all buffered entries
- in_valid  input  1  EX stage presents a branch
- in_ready  output  1  unit can accept; registered, equals (count < 2)
- br_op  input  3  condition select (encoding below)
- alu_s  input  32  ALU S result; only bit 0 is used
- alu_z  input  1  ALU zero flag
- alu_n  input  1  ALU negative flag
- alu_v  input  1  ALU overflow flag
- pc_plus4  input  W  PC of branch + 4
- offset  input  W  sign-extended 16-bit immediate, word units
- pred_taken  input  1  fetch-stage prediction
- out_valid  output  1  resolved branch available
- out_ready  input  1  PC unit consumes
- taken  output  1  resolved direction
- target  output  W  branch target
- mispredict  output  1  taken != pred_taken
- redirect_pc  output  W  target if taken, else pc_plus4
- stat_branches  output  32  resolved-branch counter (see Optional Feature)
- stat_mispred  output  32  mispredict counter (see Optional Feature)

Behaviour:
- Reset (and flush) outputs:
  - count=0, in_ready=1, out_valid=0.
  - taken, mispredict, target, redirect_pc = 0.
  - Stat counters = 0 on reset only; flush does not clear them.
- Accept: in_valid & in_ready at a rising edge.
- Condition encoding, with lt = alu_n ^ alu_v:
  - 000 BEQ: taken = alu_z
  - 001 BNE: taken = ~alu_z
  - 010 BLTZ: taken = lt
  - 011 BGEZ: taken = ~lt
  - 100 BLEZ: taken = lt | alu_z
  - 101 BGTZ: taken = ~lt & ~alu_z
  - 110 SETC: taken = alu_s[0]
  - 111 reserved: taken = 0
- Target: target = pc_plus4 + (offset << 2), modulo 2^W; wrap-around is silent.
- Result computation:
  - Computed at accept and written into the buffer.
  - Latency: accept in cycle t gives out_valid=1 in cycle t+1 when the buffer was empty.
- Buffer: 2-entry FIFO, head drives the outputs.
  - Outputs hold stable while out_valid & ~out_ready.
- Handshakes per cycle:
  - Pop only: count-1.
  - Push only: count+1.
  - Push and pop together: count unchanged, order preserved.
  - At count==2, in_ready=0 even if out_ready=1 the same cycle; no combinational ready path.
- Wrong-path kill:
  - When the head is popped with mispredict=1, any second entry is discarded in the same edge.
  - A simultaneous push in that edge is also discarded; it is younger wrong-path.
  - count becomes 0.
- Flush: count becomes 0 next edge. Flush beats simultaneous push and pop; neither is counted in the stats.
- Reset mid-operation: same as flush, plus stat counters cleared.
- States (by count): EMPTY(0), ONE(1), FULL(2).
  - EMPTY→ONE on push.
  - ONE→FULL on push without pop.
  - ONE→EMPTY on pop without push, or on pop with mispredict.
  - FULL→ONE on pop without mispredict.
  - FULL→EMPTY on mispredict pop.
  - Any→EMPTY on flush or reset.

Optional Feature:
- Macro: BRU_STATS_EN.
- Defined:
  - stat_branches increments on every pop.
  - stat_mispred increments on every pop with mispredict=1.
  - Both are 32-bit and saturate at 0xFFFFFFFF.
  - Discarded and flushed entries are not counted.
- Undefined: both stat ports are tied to 0 and no counter flops are built.

Test Plan:
- Reset, then push br_op=000, alu_z=1, pc_plus4=0x00400004, offset=0x00000003, pred_taken=1, with out_ready=1 → next cycle out_valid=1, taken=1, target=0x00400010, mispredict=0, redirect_pc=0x00400010.
- Push BLTZ with alu_n=1, alu_v=1 (lt=0), pred_taken=1, pc_plus4=0x100 → taken=0, mispredict=1, redirect_pc=0x100.
- Hold out_ready=0 and push 3 back-to-back branches → in_ready=0 after 2 accepts, third is held off, outputs stable.
- Then raise out_ready → FIFO order preserved.
- Fill both entries with head mispredict=1, then pop while in_valid=1 → count=0, next out_valid=0.
- Same sequence with BRU_STATS_EN defined → stat_mispred=1, stat_branches=1.
- pc_plus4=0xFFFFFFFC, offset=0x00000001, BNE with alu_z=0 → target=0x00000000, taken=1.
- With count=2, assert flush together with in_valid and out_ready → next cycle count=0, out_valid=0, in_ready=1, stats unchanged.
- Assert reset mid-stream → all outputs and stats return to 0.
